// File: rtl/cdc_bus_pkg.sv
// Shared definitions for the cdc_bus write-side logic: scheduler states,
// counter width and the minimum-one-bit clog2 helper.
package cdc_bus_pkg;

    typedef enum logic [1:0] {
        S_RST  = 2'd0,
        S_WAIT = 2'd1,
        S_RUN  = 2'd2
    } sched_state_e;

    localparam int WR_CNT_W = 16;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdc_bus_rr_arb.sv
// Round-robin priority picker: first valid requester at or above rr_ptr,
// wrapping past NUM_REQ-1 back to 0. Purely combinational.
module cdc_bus_rr_arb
    import cdc_bus_pkg::*;
#(
    parameter int  NUM_REQ  = 4,
    localparam int ID_WIDTH = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req_valid,
    input  logic [ID_WIDTH-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] grant_id
);

    logic                found_s;
    int                  sum_s;
    logic [ID_WIDTH-1:0] idx_s;

    // Scan NUM_REQ positions starting at rr_ptr, keep the first valid hit.
    always_comb begin
        grant    = {NUM_REQ{1'b0}};
        grant_id = {ID_WIDTH{1'b0}};
        found_s  = 1'b0;
        sum_s    = 0;
        idx_s    = {ID_WIDTH{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            sum_s = int'(rr_ptr) + k;
            if (sum_s >= NUM_REQ) begin
                sum_s = sum_s - NUM_REQ;
            end else begin
                sum_s = sum_s;
            end
            idx_s = ID_WIDTH'(sum_s);
            if (!found_s && req_valid[idx_s]) begin
                grant[idx_s] = 1'b1;
                grant_id     = idx_s;
                found_s      = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/cdc_bus_wr_sched.sv
// Write-side scheduler for the cdc_bus async FIFO: sequences the FIFO reset,
// then round-robin arbitrates requesters onto the single write port.
module cdc_bus_wr_sched
    import cdc_bus_pkg::*;
#(
    parameter int  NUM_REQ    = 4,
    parameter int  DATA_WIDTH = 32,
    parameter int  RST_CYCLES = 8,
    localparam int ID_WIDTH   = id_width(NUM_REQ)
) (
    input  logic                          clka,
    input  logic                          rsta_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          soft_rst,
    output logic                          fifo_rst,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH+ID_WIDTH-1:0] fifo_din,
    input  logic                          fifo_full,
    input  logic                          fifo_wr_rst_busy,
    output logic                          sched_rdy,
    output logic [WR_CNT_W-1:0]           wr_cnt
);

    localparam int RC_W = id_width(RST_CYCLES);

    sched_state_e          state_r;
    logic [RC_W-1:0]       rst_cnt_r;
    logic                  wait_cnt_r;
    logic [ID_WIDTH-1:0]   rr_ptr_r;
    logic                  fifo_rst_r;
    logic                  sched_rdy_r;
    logic [WR_CNT_W-1:0]   wr_cnt_r;

    logic [NUM_REQ-1:0]    grant_s;
    logic [ID_WIDTH-1:0]   grant_id_s;
    logic [ID_WIDTH-1:0]   ptr_next_s;
    logic                  xfer_s;
    logic [DATA_WIDTH-1:0] req_word_s [NUM_REQ];

    cdc_bus_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_r),
        .grant     (grant_s),
        .grant_id  (grant_id_s)
    );

    // Unpack the flat payload bus into per-requester words.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_word_s[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Grant is offered only when running and the FIFO can take a word.
    always_comb begin
        if ((state_r == S_RUN) && !fifo_full && !fifo_wr_rst_busy) begin
            req_ready = grant_s;
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
    end

    assign xfer_s     = |(req_valid & req_ready);
    assign fifo_wr_en = xfer_s;

    // Tag the granted word with its source ID; bus idles at zero.
    always_comb begin
        if (xfer_s) begin
            fifo_din = {grant_id_s, req_word_s[grant_id_s]};
        end else begin
            fifo_din = {(DATA_WIDTH+ID_WIDTH){1'b0}};
        end
    end

    // Pointer moves one past the winner so it gets lowest priority next.
    always_comb begin
        if (grant_id_s == ID_WIDTH'(NUM_REQ - 1)) begin
            ptr_next_s = {ID_WIDTH{1'b0}};
        end else begin
            ptr_next_s = grant_id_s + ID_WIDTH'(1);
        end
    end

    // Reset sequencer FSM, round-robin pointer and write counter.
    always_ff @(posedge clka) begin
        if (!rsta_n) begin
            state_r     <= S_RST;
            rst_cnt_r   <= {RC_W{1'b0}};
            wait_cnt_r  <= 1'b0;
            rr_ptr_r    <= {ID_WIDTH{1'b0}};
            fifo_rst_r  <= 1'b1;
            sched_rdy_r <= 1'b0;
            wr_cnt_r    <= {WR_CNT_W{1'b0}};
        end else begin
            if (xfer_s) begin
                rr_ptr_r <= ptr_next_s;
                wr_cnt_r <= wr_cnt_r + 16'd1;
            end
            if (soft_rst) begin
                state_r     <= S_RST;
                rst_cnt_r   <= {RC_W{1'b0}};
                wait_cnt_r  <= 1'b0;
                fifo_rst_r  <= 1'b1;
                sched_rdy_r <= 1'b0;
            end else begin
                case (state_r)
                    S_RST: begin
                        if (rst_cnt_r == RC_W'(RST_CYCLES - 1)) begin
                            state_r    <= S_WAIT;
                            wait_cnt_r <= 1'b0;
                            fifo_rst_r <= 1'b0;
                        end else begin
                            rst_cnt_r <= rst_cnt_r + RC_W'(1);
                        end
                    end
                    S_WAIT: begin
                        // Minimum two cycles here before trusting busy.
                        if (!wait_cnt_r) begin
                            wait_cnt_r <= 1'b1;
                        end else if (!fifo_wr_rst_busy) begin
                            state_r     <= S_RUN;
                            sched_rdy_r <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        // An externally triggered FIFO reset parks us in S_WAIT.
                        if (fifo_wr_rst_busy) begin
                            state_r     <= S_WAIT;
                            wait_cnt_r  <= 1'b0;
                            sched_rdy_r <= 1'b0;
                        end
                    end
                    default: begin
                        state_r     <= S_RST;
                        rst_cnt_r   <= {RC_W{1'b0}};
                        fifo_rst_r  <= 1'b1;
                        sched_rdy_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign fifo_rst  = fifo_rst_r;
    assign sched_rdy = sched_rdy_r;
    assign wr_cnt    = wr_cnt_r;

endmodule
